// File: rtl/ymat_entry_fetch.sv
// Y-matrix entry fetch: reads the SRAM words covering one row's inclusive
// entry-address range and streams the 32-bit {column, value} entries out
// over a valid/ready handshake, one entry per cycle within a word.
module ymat_entry_fetch #(
  parameter int ADDR_W    = 11,
  parameter int SLOT_BITS = 3,
  parameter int DATA_W    = 256
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             addr_first,
  input  logic [ADDR_W-1:0]             addr_last,
  output logic                          sram_rd,
  output logic [ADDR_W-SLOT_BITS-1:0]   sram_addr,
  input  logic [DATA_W-1:0]             sram_rdata,
  output logic                          ent_valid,
  input  logic                          ent_ready,
  output logic [15:0]                   ent_col,
  output logic [15:0]                   ent_val,
  output logic                          ent_last,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_W:0]               ent_count
);

  localparam int ENT_W = DATA_W >> SLOT_BITS;
  localparam logic [ADDR_W-1:0] CUR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    EMIT,
    DONE
  } state_t;

  state_t                        state_q;
  logic [ADDR_W-1:0]             cur_q;
  logic [ADDR_W-1:0]             last_q;
  logic [DATA_W-1:0]             buf_q;
  logic                          sram_rd_q;
  logic [ADDR_W-SLOT_BITS-1:0]   sram_addr_q;
  logic [ADDR_W:0]               count_q;

  logic [ADDR_W-1:0]             cur_d;
  logic [ENT_W-1:0]              slot_w;
  logic                          at_last;
  logic                          word_end;

  // Next entry address and the slot of the buffered word that cur points at
  always_comb begin
    cur_d    = cur_q + CUR_ONE;
    slot_w   = buf_q[int'(cur_q[SLOT_BITS-1:0]) * ENT_W +: ENT_W];
    at_last  = (cur_q == last_q);
    word_end = (cur_q[SLOT_BITS-1:0] == {SLOT_BITS{1'b1}});
  end

  // Row sequencer: capture range, read one word, drain its slots, repeat
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      buf_q       <= '0;
      sram_rd_q   <= 1'b0;
      sram_addr_q <= '0;
      count_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_q   <= addr_first;
            last_q  <= addr_last;
            count_q <= '0;
            if (addr_first > addr_last) begin
              state_q <= DONE;
            end else begin
              state_q     <= READ;
              sram_rd_q   <= 1'b1;
              sram_addr_q <= addr_first[ADDR_W-1:SLOT_BITS];
            end
          end
        end
        READ: begin
          sram_rd_q <= 1'b0;
          state_q   <= WAIT;
        end
        WAIT: begin
          buf_q   <= sram_rdata;
          state_q <= EMIT;
        end
        EMIT: begin
          if (ent_ready) begin
            count_q <= count_q + COUNT_ONE;
            if (at_last) begin
              state_q <= DONE;
            end else begin
              cur_q <= cur_d;
              if (word_end) begin
                state_q     <= READ;
                sram_rd_q   <= 1'b1;
                sram_addr_q <= cur_d[ADDR_W-1:SLOT_BITS];
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sram_rd   = sram_rd_q;
  assign sram_addr = sram_addr_q;
  assign ent_valid = (state_q == EMIT);
  assign ent_col   = slot_w[31:16];
  assign ent_val   = slot_w[15:0];
  assign ent_last  = (state_q == EMIT) && at_last;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign ent_count = count_q;

endmodule

// File: tb/tb_ymat_entry_fetch.sv
// Bench for ymat_entry_fetch: SRAM model, table of directed rows, a reset
// abort sequence and random rows checked against an address-range model.
module tb_ymat_entry_fetch;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [10:0]  addr_first = '0;
  logic [10:0]  addr_last = '0;
  logic         sram_rd;
  logic [7:0]   sram_addr;
  logic [255:0] sram_rdata = '0;
  logic         ent_valid;
  logic         ent_ready = 1'b0;
  logic [15:0]  ent_col;
  logic [15:0]  ent_val;
  logic         ent_last;
  logic         busy;
  logic         done;
  logic [11:0]  ent_count;

  int checks = 0;
  int errors = 0;

  logic [255:0] mem [256];

  typedef struct {
    logic [10:0] first;
    logic [10:0] last;
    int          readyMode;
    bit          midStart;
    int          expCount;
    int          expReads;
  } vec_t;

  ymat_entry_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .addr_first (addr_first),
    .addr_last  (addr_last),
    .sram_rd    (sram_rd),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .ent_valid  (ent_valid),
    .ent_ready  (ent_ready),
    .ent_col    (ent_col),
    .ent_val    (ent_val),
    .ent_last   (ent_last),
    .busy       (busy),
    .done       (done),
    .ent_count  (ent_count)
  );

  always #5 clock = ~clock;

  // SRAM with one-cycle read latency; garbage on the bus when not reading
  always @(posedge clock) begin
    if (sram_rd) begin
      sram_rdata <= mem[sram_addr];
    end else begin
      for (int i = 0; i < 8; i++) sram_rdata[32*i +: 32] <= $urandom;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag, input logic [11:0] expCount);
    checkOutput({tag, " sram_rd"}, sram_rd, 0);
    checkOutput({tag, " ent_valid"}, ent_valid, 0);
    checkOutput({tag, " ent_last"}, ent_last, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " ent_count"}, ent_count, expCount);
  endtask

  // Run one row and compare the DUT against the entry list derived from the range
  task automatic applyStimulus(input logic [10:0] first, input logic [10:0] last,
                               input int readyMode, input bit midStart,
                               input int expCount, input int expReads);
    logic [31:0] expQ[$];
    int          wordQ[$];
    int          fA, lA, cyc, reads, accepted, validIdx, expDone;
    bit          seenDone, firstValid, prevStall, injected, r;
    logic [31:0] prevEnt;
    logic        prevLast;
    fA = int'(first);
    lA = int'(last);
    for (int a = fA; a <= lA; a++) begin
      expQ.push_back(mem[a >> 3][32*(a % 8) +: 32]);
      if (a == fA || (a % 8) == 0) wordQ.push_back(a >> 3);
    end
    expDone = 1 + 2 * wordQ.size() + expQ.size();
    cyc = 0; reads = 0; accepted = 0; validIdx = 0;
    seenDone = 0; firstValid = 1; prevStall = 0; injected = 0;
    prevEnt = '0; prevLast = 0;

    @(negedge clock);
    start = 1'b1; addr_first = first; addr_last = last; ent_ready = 1'b0;
    @(posedge clock);
    while (!seenDone) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      checkOutput("busy in row", busy, 1);
      checkOutput("ent_count running", ent_count, accepted);
      if (sram_rd) begin
        reads++;
        if (wordQ.size() == 0) checkOutput("unexpected sram_rd", 1, 0);
        else checkOutput("sram_addr", sram_addr, wordQ.pop_front());
      end
      if (ent_valid) begin
        if (firstValid) begin
          checkOutput("first valid latency", cyc, 3);
          firstValid = 0;
        end
        if (prevStall) begin
          checkOutput("stall hold entry", {ent_col, ent_val}, prevEnt);
          checkOutput("stall hold last", ent_last, prevLast);
        end
        if (expQ.size() == 0) begin
          checkOutput("extra entry", 1, 0);
        end else begin
          checkOutput("entry", {ent_col, ent_val}, expQ[0]);
          checkOutput("ent_last", ent_last, (expQ.size() == 1));
        end
        case (readyMode)
          0: r = 1'b1;
          1: r = ((validIdx % 4) == 0) || ((validIdx % 4) == 3);
          default: r = 1'($urandom_range(0, 1));
        endcase
        validIdx++;
        ent_ready = r;
        if (r && expQ.size() != 0) begin
          void'(expQ.pop_front());
          accepted++;
        end
        prevStall = !r;
        prevEnt = {ent_col, ent_val};
        prevLast = ent_last;
        if (midStart && !injected) begin
          start = 1'b1; addr_first = 11'h100; addr_last = 11'h1FF;
          injected = 1;
        end
      end else begin
        if (prevStall) checkOutput("entry dropped during stall", 0, 1);
        prevStall = 0;
        ent_ready = (readyMode == 0);
      end
      if (done) seenDone = 1;
      if (cyc > 5000 && !seenDone) begin
        checkOutput("row timeout", 0, 1);
        break;
      end
    end
    checkOutput("done seen", seenDone, 1);
    checkOutput("entries left", expQ.size(), 0);
    checkOutput("reads", reads, expReads);
    checkOutput("ent_count at done", ent_count, expCount);
    if (readyMode == 0) checkOutput("done cycle", cyc, expDone);
    @(negedge clock);
    start = 1'b0;
    ent_ready = 1'b0;
    checkIdleOutputs("after done", 12'(expCount));
  endtask

  vec_t vecs [9];

  initial begin
    int acc;
    int f, len, l, cnt, rds;
    for (int w = 0; w < 256; w++)
      for (int s = 0; s < 8; s++) mem[w][32*s +: 32] = $urandom;
    for (int k = 0; k < 8; k++) mem[2][32*k +: 32] = {16'(k), 16'(16'h1000 + k)};

    vecs[0] = '{11'h010, 11'h013, 0, 0, 4, 1};
    vecs[1] = '{11'h00E, 11'h011, 0, 0, 4, 2};
    vecs[2] = '{11'h010, 11'h013, 1, 0, 4, 1};
    vecs[3] = '{11'h020, 11'h01F, 0, 0, 0, 0};
    vecs[4] = '{11'h7FF, 11'h7FF, 0, 0, 1, 1};
    vecs[5] = '{11'h008, 11'h00F, 0, 1, 8, 1};
    vecs[6] = '{11'h005, 11'h01A, 2, 0, 22, 4};
    vecs[7] = '{11'h000, 11'h000, 0, 0, 1, 1};
    vecs[8] = '{11'h7F0, 11'h7FF, 1, 0, 16, 2};

    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkIdleOutputs("reset", 12'd0);
    checkOutput("reset sram_addr", sram_addr, 0);
    checkOutput("reset ent_col", ent_col, 0);
    checkOutput("reset ent_val", ent_val, 0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++)
      applyStimulus(vecs[i].first, vecs[i].last, vecs[i].readyMode,
                    vecs[i].midStart, vecs[i].expCount, vecs[i].expReads);

    // Abort a row after two accepted entries
    @(negedge clock);
    start = 1'b1; addr_first = 11'h018; addr_last = 11'h01F; ent_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (ent_valid) acc++;
    end
    checkOutput("abort reached two entries", acc, 2);
    @(negedge clock);
    checkOutput("abort ent_count before reset", ent_count, 2);
    reset = 1'b0;
    ent_ready = 1'b0;
    @(negedge clock);
    checkIdleOutputs("abort", 12'd0);
    checkOutput("abort sram_addr", sram_addr, 0);
    checkOutput("abort ent_col", ent_col, 0);
    checkOutput("abort ent_val", ent_val, 0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("no done after abort", done, 0);
    end
    applyStimulus(11'h018, 11'h01F, 0, 0, 8, 1);

    // Random rows, including empty ranges
    for (int n = 0; n < 24; n++) begin
      f = $urandom_range(0, 2047);
      len = $urandom_range(0, 24);
      if (len == 0) begin
        if (f == 0) f = 5;
        l = f - 1 - int'($urandom_range(0, 3));
        if (l < 0) l = 0;
      end else begin
        l = f + len - 1;
        if (l > 2047) l = 2047;
      end
      cnt = (l >= f) ? (l - f + 1) : 0;
      rds = (l >= f) ? ((l >> 3) - (f >> 3) + 1) : 0;
      applyStimulus(11'(f), 11'(l), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    cnt, rds);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ymat_entry_fetch.md
Name: ymat_entry_fetch

Overview:
- Downstream of the Y-matrix row-address stage. Consumes the inclusive entry-address pair produced for one matrix row (first entry, last entry).
- Reads the covered 256-bit Y-matrix SRAM words one at a time.
- Unpacks each word into 32-bit {column, value} entries and streams them to the update engine over a valid/ready handshake.
- Reports one done pulse per row and the number of entries emitted.

Parameters:
- ADDR_W, 11, entry address width; upper ADDR_W-SLOT_BITS bits = SRAM word address, lower SLOT_BITS bits = slot in word
- SLOT_BITS, 3, log2 entries per SRAM word (8 entries x 32 bits = 256)
- DATA_W, 256, SRAM read data width

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 on a rising edge resets the block)
- start  in  1  begin fetch of one row; sampled only in IDLE
- addr_first  in  11  first entry address of row (inclusive)
- addr_last  in  11  last entry address of row (inclusive)
- sram_rd  out  1  SRAM read strobe
- sram_addr  out  8  SRAM word address
- sram_rdata  in  256  SRAM read data, valid the cycle after sram_rd
- ent_valid  out  1  entry valid
- ent_ready  in  1  downstream accepts entry
- ent_col  out  16  entry column index = slot[31:16]
- ent_val  out  16  entry value = slot[15:0]
- ent_last  out  1  entry is the one at addr_last
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of row
- ent_count  out  12  entries emitted for current/last row

Behaviour:
- Reset values: all outputs 0, state IDLE, internal buffer cleared; ent_count=0.
- Reset mid-operation: abort immediately to IDLE; no done pulse; in-flight SRAM data discarded.
- Start capture:
  - In IDLE with start=1: latch addr_first/addr_last, cur<=addr_first, ent_count<=0.
  - start is ignored in all other states.
- Empty range (addr_first > addr_last, unsigned): go IDLE->DONE; no SRAM read; no entries; done pulses; ent_count stays 0.
- States and timing:
  - IDLE.
  - READ: sram_rd=1, sram_addr=cur[10:3], one cycle.
  - WAIT: capture sram_rdata into buffer at end of this cycle.
  - EMIT.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: start sampled at edge N -> sram_rd high cycle N+1 -> buffer loaded end of N+2 -> ent_valid high from cycle N+3.
- EMIT:
  - ent_valid=1 and ent_col/ent_val = buffer[32*cur[2:0] +: 32] split as above.
  - ent_last = (cur==addr_last).
  - Outputs are held stable while ent_ready=0.
- On ent_valid && ent_ready:
  - ent_count++.
  - If cur==addr_last, go DONE.
  - Else if cur[2:0]==7, cur++ and go READ (next word; 2-cycle bubble, no prefetch).
  - Else cur++ and stay in EMIT (one entry per cycle under continuous ready).
- First word may start mid-word (addr_first[2:0]!=0); lower slots are skipped. The last word may end mid-word.
- sram_addr holds its last value when sram_rd=0. sram_rd is never high outside READ.
- ent_count holds after done until the next accepted start. Max row length 2048 entries fits 12 bits.
- busy deasserts in the cycle after DONE (IDLE); a start in that IDLE cycle is accepted.

Test Plan:
- Single-word row: start, addr_first=0x010, addr_last=0x013, word 2 slots k: col=k, val=0x1000+k, ready=1 -> sram_rd once at addr 2, entries (0,0x1000)..(3,0x1003) on 4 consecutive cycles starting N+3, ent_last on 4th, done next cycle, ent_count=4.
- Word-crossing row: addr_first=0x00E, addr_last=0x011, ready=1 -> reads word 1 then word 2, entries slots 6,7 of word1 then 0,1 of word2, 2-cycle ent_valid gap between words, ent_count=4.
- Backpressure: same as first case with ent_ready toggling 1,0,0,1... -> ent_col/ent_val stable while ready=0, no entry dropped or duplicated, ent_count=4.
- Empty/degenerate: addr_first=0x020, addr_last=0x01F -> no sram_rd, no ent_valid, done one cycle, ent_count=0; addr_first=addr_last=0x7FF -> one read at addr 0xFF, one entry slot 7 with ent_last=1.
- Reset mid-row: reset=0 while in EMIT after 2 of 8 entries -> next cycle all outputs 0, IDLE, no done; new start fetches correctly from scratch.
- Start while busy: pulse start with different addresses during EMIT -> ignored, original row completes unaffected.
